// File: rtl/bram_stream_writer.sv
// rtl/bram_stream_writer.sv - stream-to-BRAM write feeder with input FIFO and circular address window
// Optional feature macro: BSW_FRAME_CNT_EN (frame_cnt counter built when defined, tied to 0 otherwise)

module bram_stream_writer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [31:0] ADDR_STEP  = 32'd4,
    parameter logic [31:0] WIN_BYTES  = 32'h1000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic [15:0] words_written,
    output logic        frame_done,
    output logic        wrapped,
    output logic [15:0] frame_cnt
);

    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] WIN_END   = BASE_ADDR + WIN_BYTES;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [32:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic [AW:0]     count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            rst_done;
    logic            start_take;
    logic            push;
    logic            pop;
    logic            accept;

    logic [31:0]     ptr;
    logic [31:0]     ptr_inc;
    logic [31:0]     ptr_next;
    logic            wrap_hit;
    logic            last_q;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // s_ready uses only registered state (plus start), so wr_ready never reaches it combinationally
    assign busy       = !fifo_empty || wr_valid;
    assign start_take = start && !busy;
    assign s_ready    = rst_done && !fifo_full && !start_take;
    assign push       = s_valid && s_ready;

    assign ptr_inc    = ptr + ADDR_STEP;
    assign wrap_hit   = (ptr_inc == WIN_END);
    assign ptr_next   = wrap_hit ? BASE_ADDR : ptr_inc;

    // Hold s_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // FIFO storage: {last, data}; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= {s_last, s_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output FSM: load a write from the FIFO, hold it until accepted, chain the next one without a bubble
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        accept     = 1'b0;
        wr_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    accept = 1'b1;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write datapath: address pointer, output registers, counters and status pulses
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr           <= BASE_ADDR;
            wr_addr       <= '0;
            wr_data       <= '0;
            last_q        <= 1'b0;
            words_written <= '0;
            frame_done    <= 1'b0;
            wrapped       <= 1'b0;
        end else begin
            frame_done <= accept && last_q;
            wrapped    <= accept && wrap_hit;
            if (start_take) begin
                ptr           <= BASE_ADDR;
                words_written <= '0;
            end else if (accept) begin
                ptr           <= ptr_next;
                words_written <= words_written + 16'd1;
            end
            if (pop) begin
                wr_data <= mem[rd_idx][31:0];
                last_q  <= mem[rd_idx][32];
                // a pop chained onto an accept targets the address after the one just written
                wr_addr <= accept ? ptr_next : ptr;
            end
        end
    end

`ifdef BSW_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter; a start clears it even if a frame completes the same cycle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_cnt_q <= '0;
        end else if (start_take) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
